// File: rtl/fifo_wr_arbiter.sv
// Round-robin, credit-gated arbiter for the shared FIFO write port.
// Define FIFO_ARB_WRACK_CHK_EN to enable the sticky write-ack checker.
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [FIFO_WIDTH-1:0]             fifo_data_in,
  output logic                              fifo_wr_en,
  input  logic                              fifo_wr_ack,
  input  logic                              fifo_rd_en,
  input  logic                              fifo_empty,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   credits,
  output logic                              ack_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IW:0]   NREQ_C  = (IW+1)'(NUM_REQ);

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         gnt_idx;
  logic                  found;
  logic [IW:0]           sum;
  logic                  rd_ok;
  logic [FIFO_WIDTH-1:0] req_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_arr[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  assign rd_ok = fifo_rd_en && !fifo_empty;

  // Search upward from rr_ptr, wrapping, for the first valid requester.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    found     = 1'b0;
    sum       = '0;
    if (rst_n && credits != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (IW+1)'(k);
        if (sum >= NREQ_C) sum = sum - NREQ_C;
        if (!found && req_valid[sum[IW-1:0]]) begin
          found   = 1'b1;
          gnt_idx = sum[IW-1:0];
        end
      end
      if (found) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits      <= DEPTH_C;
      rr_ptr       <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      grant_id     <= '0;
    end else begin
      fifo_wr_en <= found;
      if (found) begin
        fifo_data_in <= req_arr[gnt_idx];
        grant_id     <= gnt_idx;
        rr_ptr       <= (gnt_idx == IW'(NUM_REQ-1)) ?
                        '0 : gnt_idx + IW'(1);
      end
      // A read and a write in the same cycle cancel out.
      unique case (1'b1)
        (found && !rd_ok):
          credits <= credits - CW'(1);
        (rd_ok && !found && credits != DEPTH_C):
          credits <= credits + CW'(1);
        default: ;
      endcase
    end
  end

`ifdef FIFO_ARB_WRACK_CHK_EN
  logic [1:0] wr_sh;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sh <= '0;
      err_q <= 1'b0;
    end else begin
      wr_sh <= {wr_sh[0], fifo_wr_en};
      if (wr_sh[1] && !fifo_wr_ack) err_q <= 1'b1;
    end
  end

  assign ack_err = err_q;
`else
  logic unused_wr_ack;
  assign unused_wr_ack = fifo_wr_ack;
  assign ack_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a behavioural model.
// Covers the FIFO_ARB_WRACK_CHK_EN checker when that macro is defined.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] fifo_data_in;
  logic        fifo_wr_en;
  logic        fifo_wr_ack;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [1:0]  grant_id;
  logic [3:0]  credits;
  logic        ack_err;

  int errs   = 0;
  int checks = 0;

  int          m_cred;
  int          m_rr;
  int          m_gid;
  logic        m_wr;
  logic [15:0] m_data;
  logic        m_err;
  logic        h1;
  logic        h2;
  logic [3:0]  m_ready;

  fifo_wr_arbiter #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(8),
    .NUM_REQ(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_data_in(fifo_data_in),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_ack(fifo_wr_ack),
    .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty),
    .grant_id(grant_id),
    .credits(credits),
    .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cred = 8;
    m_rr   = 0;
    m_gid  = 0;
    m_wr   = 1'b0;
    m_data = '0;
    m_err  = 1'b0;
    h1     = 1'b0;
    h2     = 1'b0;
  endtask

  function automatic logic [3:0] m_arb(input logic [3:0] v);
    logic [3:0] r;
    r = '0;
    if (m_cred > 0) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_rr + k) % 4;
        if (r == 0 && v[j]) r[j] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check_regs();
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr));
    check("fifo_data_in", 32'(fifo_data_in), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("credits", 32'(credits), 32'(m_cred));
    check("ack_err", 32'(ack_err), 32'(m_err));
  endtask

  // Called just after a falling edge; returns on the next falling edge.
  task automatic step(input logic [3:0] v, input logic rd,
                      input logic emp, input logic ack);
    logic rd_ok;
    logic g;
    req_valid   = v;
    fifo_rd_en  = rd;
    fifo_empty  = emp;
    fifo_wr_ack = ack;
    #1;
    m_ready = m_arb(v);
    check("req_ready", 32'(req_ready), 32'(m_ready));
    @(posedge clk);
    rd_ok = rd && !emp;
    g     = (m_ready & v) != 0;
`ifdef FIFO_ARB_WRACK_CHK_EN
    if (h2 && !ack) m_err = 1'b1;
    h2 = h1;
    h1 = m_wr;
`endif
    m_wr = g;
    if (g) begin
      for (int j = 0; j < 4; j++) begin
        if (m_ready[j]) begin
          m_gid  = j;
          m_data = req_data[j*16 +: 16];
          m_rr   = (j + 1) % 4;
        end
      end
    end
    if (g && !rd_ok) m_cred--;
    else if (rd_ok && !g && m_cred < 8) m_cred++;
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_data    = '0;
    fifo_wr_ack = 1'b1;
    fifo_rd_en  = 1'b0;
    fifo_empty  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_credits", 32'(credits), 32'd8);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_ack_err", 32'(ack_err), 32'd0);

    req_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    for (int i = 0; i < 10; i++) begin
      step(4'hF, 1'b0, 1'b0, 1'b1);
      if (i < 8) begin
        check("seq_grant", 32'(grant_id), 32'(i % 4));
        check("seq_data", 32'(fifo_data_in), 32'(16'hA000 + i % 4));
      end
    end
    #1;
    check("full_credits", 32'(credits), 32'd0);
    check("full_ready", 32'(req_ready), 32'd0);
    check("full_wr_en", 32'(fifo_wr_en), 32'd0);

    step(4'hF, 1'b1, 1'b0, 1'b1);
    check("ret_credit", 32'(credits), 32'd1);
    step(4'hF, 1'b0, 1'b0, 1'b1);
    check("ret_grant", 32'(grant_id), 32'd0);
    check("ret_credit0", 32'(credits), 32'd0);

    repeat (8) step(4'h0, 1'b1, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    check("r2_first", 32'(grant_id), 32'd2);
    step(4'b0100, 1'b0, 1'b0, 1'b1);
    check("r2_second", 32'(grant_id), 32'd2);
    step(4'b1010, 1'b0, 1'b0, 1'b1);
    check("r3_before_r1", 32'(grant_id), 32'd3);
    step(4'b1010, 1'b0, 1'b0, 1'b1);
    check("r1_after", 32'(grant_id), 32'd1);

    step(4'b0001, 1'b0, 1'b0, 1'b1);
    check("cred3", 32'(credits), 32'd3);
    step(4'b0001, 1'b1, 1'b0, 1'b1);
    check("cred3_both", 32'(credits), 32'd3);
    repeat (6) step(4'h0, 1'b1, 1'b0, 1'b1);
    check("cred_sat", 32'(credits), 32'd8);
    step(4'h0, 1'b1, 1'b0, 1'b1);
    check("cred_sat2", 32'(credits), 32'd8);

    for (int i = 0; i < 400; i++) begin
      req_data = {$urandom, $urandom};
      step(4'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, 1'b1);
    end

    repeat (8) step(4'h0, 1'b1, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0, 1'b1);
    check("pre_rst_wr", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr", 32'(fifo_wr_en), 32'd0);
    check("mid_rst_cred", 32'(credits), 32'd8);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_data", 32'(fifo_data_in), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'hF, 1'b0, 1'b0, 1'b1);
    check("post_rst_grant", 32'(grant_id), 32'd0);

`ifdef FIFO_ARB_WRACK_CHK_EN
    step(4'b0001, 1'b0, 1'b0, 1'b1);
    repeat (4) step(4'h0, 1'b0, 1'b0, 1'b0);
    check("ack_err_set", 32'(ack_err), 32'd1);
    repeat (3) step(4'h0, 1'b0, 1'b0, 1'b1);
    check("ack_err_sticky", 32'(ack_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ack_err_rst", 32'(ack_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'h0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
